// File: rtl/uart_tx_module.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, stop bit.
// Handshake: TX_En_Sig is taken only in IDLE; TX_Busy covers the frame, TX_Done_Sig pulses once at its end.
module uart_tx_module #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       TX_En_Sig,
  input  logic [7:0] TX_data,
  output logic       TX_Pin_Out,
  output logic       TX_Busy,
  output logic       TX_Done_Sig,
  output logic [2:0] dbg_state
);

  localparam int BPS_CNT = CLK_FREQ / BAUD;
  localparam int CNT_W   = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BPS_CNT - 1);
  localparam logic PE_BIT  = (PARITY_EN != 0);
  localparam logic ODD_BIT = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bit_end;
  logic [2:0]       bit_nxt;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // tx_d carries the line value of the state being entered, so the pin stays a pure flop.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    tx_d     = tx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    bit_end  = (baud_q == CNT_LAST);
    bit_nxt  = bit_q + 3'd1;

    if (state_q != S_IDLE) begin
      baud_d = bit_end ? '0 : baud_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (TX_En_Sig) begin
          shift_d  = TX_data;
          parity_d = (^TX_data) ^ ODD_BIT;
          state_d  = S_START;
          baud_d   = '0;
          bit_d    = '0;
          tx_d     = 1'b0;
          busy_d   = 1'b1;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            if (PE_BIT) begin
              state_d = S_PARITY;
              tx_d    = parity_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_nxt;
            tx_d  = shift_q[bit_nxt];
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          tx_d    = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign TX_Pin_Out  = tx_q;
  assign TX_Busy     = busy_q;
  assign TX_Done_Sig = done_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_uart_tx_module.sv
// Bench for uart_tx_module: three instances (no parity, even, odd) share stimulus;
// one line monitor per instance decodes frames against the expected byte queue.
module tb_uart_tx_module;

  localparam int B = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] data = 8'h00;
  logic [2:0] line, busy, done;
  logic [2:0] st0, st1, st2;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  int rd_idx[3] = '{0, 0, 0};

  always #5 clk = ~clk;

  uart_tx_module #(.CLK_FREQ(1000), .BAUD(100), .PARITY_EN(0), .PARITY_ODD(0)) u_dut_np (
    .sys_clk(clk), .rst_n(rst_n), .TX_En_Sig(en), .TX_data(data),
    .TX_Pin_Out(line[0]), .TX_Busy(busy[0]), .TX_Done_Sig(done[0]), .dbg_state(st0));
  uart_tx_module #(.CLK_FREQ(1000), .BAUD(100), .PARITY_EN(1), .PARITY_ODD(0)) u_dut_pe (
    .sys_clk(clk), .rst_n(rst_n), .TX_En_Sig(en), .TX_data(data),
    .TX_Pin_Out(line[1]), .TX_Busy(busy[1]), .TX_Done_Sig(done[1]), .dbg_state(st1));
  uart_tx_module #(.CLK_FREQ(1000), .BAUD(100), .PARITY_EN(1), .PARITY_ODD(1)) u_dut_po (
    .sys_clk(clk), .rst_n(rst_n), .TX_En_Sig(en), .TX_data(data),
    .TX_Pin_Out(line[2]), .TX_Busy(busy[2]), .TX_Done_Sig(done[2]), .dbg_state(st2));

  task automatic check(input string name, input int k, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, k, got, exp, $time);
    end
  endtask

  // Line decoder and scoreboard for instance k.
  task automatic monitor(input int k);
    logic        pe;
    logic        odd;
    int          nb;
    logic [7:0]  e;
    logic [10:0] fb;
    logic [10:0] samp;
    logic        held_ok;
    logic        busy_ok;
    logic        aborted;
    pe  = (k != 0);
    odd = (k == 2);
    nb  = pe ? 11 : 10;
    forever begin
      @(negedge clk);
      if (!rst_n) continue;
      if (done[k]) check("idle_done", k, 32'(done[k]), 0);
      if (line[k] === 1'b0) begin
        if (rd_idx[k] >= exp_q.size()) begin
          check("unexpected_frame", k, rd_idx[k], exp_q.size());
          repeat (nb * B) @(negedge clk);
          continue;
        end
        e = exp_q[rd_idx[k]];
        rd_idx[k]++;
        fb = '1;
        fb[0] = 1'b0;
        fb[8:1] = e;
        if (pe) fb[9] = (^e) ^ odd;
        samp = '0;
        held_ok = 1'b1;
        busy_ok = 1'b1;
        aborted = 1'b0;
        for (int i = 0; i < nb; i++) begin
          for (int c = 0; c < B; c++) begin
            if (!(i == 0 && c == 0)) @(negedge clk);
            if (!rst_n) begin
              aborted = 1'b1;
              break;
            end
            if (line[k] !== fb[i]) held_ok = 1'b0;
            if (busy[k] !== 1'b1 || done[k] !== 1'b0) busy_ok = 1'b0;
            if (c == B / 2) samp[i] = line[k];
          end
          if (aborted) break;
        end
        if (aborted) begin
          wait (rst_n === 1'b1);
          continue;
        end
        check("bit_hold", k, 32'(held_ok), 1);
        check("busy_frame", k, 32'(busy_ok), 1);
        check("rx_byte", k, 32'(samp[8:1]), 32'(e));
        if (pe) check("parity_bit", k, 32'(samp[9]), 32'(fb[9]));
        check("stop_bit", k, 32'(samp[nb-1]), 1);
        @(negedge clk);
        if (!rst_n) continue;
        check("done_pulse", k, 32'(done[k]), 1);
        check("busy_in_done", k, 32'(busy[k]), 0);
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);
  initial monitor(2);

  task automatic send(input logic [7:0] b);
    @(posedge clk) #1;
    data = b;
    en   = 1'b1;
    exp_q.push_back(b);
    @(posedge clk) #1;
    en = 1'b0;
  endtask

  task automatic wait_all_idle();
    int n;
    n = 0;
    while ((busy !== 3'b000 || done !== 3'b000 || line !== 3'b111) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check("idle_timeout", 0, 32'(busy), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_done(input int k);
    int n;
    n = 0;
    @(negedge clk);
    while (done[k] !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check("done_timeout", k, 32'(done[k]), 1);
  endtask

  initial begin
    #12;
    check("reset_line", 0, 32'(line), 32'h7);
    check("reset_busy", 0, 32'(busy), 0);
    check("reset_done", 0, 32'(done), 0);
    check("reset_state", 0, 32'(st0), 0);
    @(posedge clk) #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Basic frame and parity frames.
    send(8'hA5);
    wait_all_idle();
    send(8'h07);
    wait_all_idle();

    // Request while busy must be dropped.
    send(8'h3C);
    repeat (30) @(posedge clk);
    #1;
    data = 8'hFF;
    en   = 1'b1;
    @(posedge clk) #1;
    en = 1'b0;
    wait_all_idle();
    repeat (150) @(negedge clk);
    check("idle_line", 0, 32'(line), 32'h7);

    // Back-to-back with data changed in the done cycle.
    @(posedge clk) #1;
    data = 8'h55;
    en   = 1'b1;
    exp_q.push_back(8'h55);
    wait_done(0);
    data = 8'hAA;
    exp_q.push_back(8'hAA);
    @(negedge clk);
    check("b2b_start", 0, 32'(line[0]), 0);
    check("b2b_busy", 0, 32'(busy[0]), 1);
    wait_done(1);
    @(posedge clk) #1;
    en = 1'b0;
    wait_all_idle();

    // Asynchronous reset during data bit 3.
    send(8'hC3);
    repeat (44) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_line", 0, 32'(line), 32'h7);
    check("rst_busy", 0, 32'(busy), 0);
    check("rst_done", 0, 32'(done), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_line", 0, 32'(line), 32'h7);
    send(8'h81);
    wait_all_idle();

    // Loopback bytes.
    send(8'h00);
    wait_all_idle();
    send(8'hFF);
    wait_all_idle();
    send(8'h5A);
    wait_all_idle();
    repeat (20) @(negedge clk);

    for (int k = 0; k < 3; k++) check("frames_seen", k, rd_idx[k], exp_q.size());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_module.md
Name: uart_tx_module

Overview:
UART transmitter, the transmit counterpart of the existing UART receive path in the ZYNQ USART block.
- Accepts one parallel byte per request and serialises it onto TX_Pin_Out: start bit, 8 data bits LSB first, optional parity bit, stop bit.
- Contains its own baud counter, bit counter and frame state machine.
- Returns a busy level and a one-cycle done pulse to the requesting logic.

Parameters:
CLK_FREQ, 50000000, sys_clk frequency in Hz
BAUD, 115200, line rate in bit/s; BPS_CNT = CLK_FREQ/BAUD (integer division, must be >= 2) clocks per bit
PARITY_EN, 0, 1 = insert parity bit after data bits, 0 = no parity
PARITY_ODD, 0, 1 = odd parity, 0 = even parity; ignored when PARITY_EN = 0

Ports:
sys_clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
TX_En_Sig  input  1  transmit request, sampled every cycle
TX_data  input  8  byte to send, sampled on the accepted request cycle
TX_Pin_Out  output  1  serial line, idle high, registered
TX_Busy  output  1  high from the cycle after acceptance until the done cycle (exclusive)
TX_Done_Sig  output  1  one-cycle pulse at end of stop bit

Behaviour:
- Reset (rst_n low, asynchronous): TX_Pin_Out=1, TX_Busy=0, TX_Done_Sig=0, state=IDLE, baud counter=0, bit counter=0, shift register=0.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - If TX_En_Sig=1 at a rising edge, latch TX_data into the shift register.
  - Compute the parity bit: XOR of the bits, inverted for odd.
  - Enter START with baud counter=0.
  - Next cycle: TX_Pin_Out=0, TX_Busy=1. Latency from sampled request to line low is one clock.
- Bit timing: the baud counter runs 0..BPS_CNT-1 in every non-IDLE state. The line value is held for exactly BPS_CNT clocks per bit. The state or bit advances when the counter is BPS_CNT-1; the counter then wraps to 0.
- START: line 0 for BPS_CNT clocks, then DATA with bit counter=0.
- DATA: line = shift register bit[bit counter], bit 0 first. After bit 7, go to PARITY if PARITY_EN=1, else STOP.
- PARITY: line = parity bit for BPS_CNT clocks, then STOP.
- STOP: line 1 for BPS_CNT clocks. On the last clock:
  - next state is IDLE;
  - TX_Done_Sig=1 for exactly that one following cycle;
  - TX_Busy=0 in that same cycle.
- Frame length: (10 + PARITY_EN)*BPS_CNT clocks from line-low to the TX_Done_Sig cycle.
- TX_En_Sig while busy (any non-IDLE state): ignored, not queued. TX_data changes mid-frame have no effect.
- Back-to-back: a request present in the TX_Done_Sig cycle (state IDLE) is accepted. The next start bit begins the following cycle, so the stop bit is never shortened.
- TX_En_Sig held high continuously gives continuous frames with a full-length stop bit between them.
- Reset mid-frame: immediate abort. The line returns high asynchronously and no done pulse is generated.
- TX_Pin_Out is a direct register output with no combinational path from inputs.

Test Plan:
1. Basic frame. Parameters: CLK_FREQ=1000, BAUD=100 (BPS_CNT=10), PARITY_EN=0. Stimulus: pulse TX_En_Sig with TX_data=8'hA5. Required response: line sequence 0,1,0,1,0,0,1,0,1,1, each bit 10 clocks; TX_Done_Sig high for exactly 1 cycle, 100 clocks after line-low; TX_Busy high for 100 cycles.
2. Parity. PARITY_EN=1, PARITY_ODD=0, TX_data=8'h07: parity bit=1, frame 110 clocks. With PARITY_ODD=1: parity bit=0.
3. Busy rejection. Send 8'h3C, then pulse TX_En_Sig with 8'hFF mid-frame. Required: only 8'h3C appears on the line, one TX_Done_Sig, line stays high afterwards.
4. Back-to-back. Hold TX_En_Sig=1 with TX_data 8'h55 then 8'hAA (change data in the done cycle). Required: two complete frames, stop bit exactly 10 clocks, second start bit in the cycle after the first TX_Done_Sig.
5. Reset mid-frame. Assert rst_n low during data bit 3. Required: TX_Pin_Out=1 and TX_Busy=0 immediately (asynchronous), no TX_Done_Sig. After release, a new request for 8'h81 transmits correctly.
6. Receiver loopback. Connect TX_Pin_Out to the UART receive path at matching baud and send 0x00, 0xFF, 0x5A. Required: received bytes match and the receive done pulse fires once per frame.
